// File: rtl/booth_mul_arbiter_if.sv
// rtl/booth_mul_arbiter_if.sv - request/result channel bundle for the shared Booth multiplier arbiter
//
// Purpose: groups the per-requester operand channel and the shared result
// channel of booth_mul_arbiter into one interface.
// Signals:
//   req_valid[N_REQ]         requester -> arbiter, operand pair valid
//   req_ready[N_REQ]         arbiter -> requester, one-hot (or zero) accept
//   req_a[N_REQ*WIDTH_A]     packed A operands, requester k at [k*WIDTH_A +: WIDTH_A]
//   req_b[N_REQ*WIDTH_B]     packed B operands, same packing
//   res_valid / res_ready    result handshake
//   res_data[WIDTH_MUL]      product
//   res_id[ID_W]             index of the requester owning res_data
// Modports: master = requester/consumer side, slave = arbiter side.

interface booth_mul_arbiter_if #(
  parameter int N_REQ     = 4,
  parameter int ID_W      = 2,
  parameter int WIDTH_A   = 16,
  parameter int WIDTH_B   = 16,
  parameter int WIDTH_MUL = WIDTH_A + WIDTH_B
);
  logic [N_REQ-1:0]         req_valid;
  logic [N_REQ-1:0]         req_ready;
  logic [N_REQ*WIDTH_A-1:0] req_a;
  logic [N_REQ*WIDTH_B-1:0] req_b;
  logic                     res_valid;
  logic                     res_ready;
  logic [WIDTH_MUL-1:0]     res_data;
  logic [ID_W-1:0]          res_id;

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_data, res_id
  );

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_data, res_id
  );
endinterface

// File: rtl/booth_mul_arbiter.sv
// rtl/booth_mul_arbiter.sv - round-robin arbiter sharing one iterative Booth multiplier
//
// Purpose: grants one of N_REQ requesters round-robin, latches its operands
// into the engine operand registers, holds mul_en for MUL_LAT cycles, captures
// the product and returns it with the requester index on the result channel.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   bus            booth_mul_arbiter_if.slave (request and result channels)
//   busy           high whenever the FSM is not IDLE
//   mul_en         engine step enable (high for exactly MUL_LAT cycles per op)
//   mul_a, mul_b   registered engine operands, stable for the whole operation
//   mul_out        engine product, sampled one cycle after mul_en falls
// Optional (macro BOOTH_ARB_STATS_EN):
//   op_count       completed result handshakes, wraps
//   stall_count    RESP cycles with res_ready low, saturates

module booth_mul_arbiter #(
  parameter int N_REQ     = 4,
  parameter int ID_W      = 2,
  parameter int WIDTH_A   = 16,
  parameter int WIDTH_B   = 16,
  parameter int WIDTH_MUL = WIDTH_A + WIDTH_B,
  parameter int MUL_LAT   = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  booth_mul_arbiter_if.slave    bus,
  output logic                  busy,
  output logic                  mul_en,
  output logic [WIDTH_A-1:0]    mul_a,
  output logic [WIDTH_B-1:0]    mul_b,
  input  logic [WIDTH_MUL-1:0]  mul_out
`ifdef BOOTH_ARB_STATS_EN
  ,
  output logic [31:0]           op_count,
  output logic [31:0]           stall_count
`endif
);

  // Wide enough to hold MUL_LAT, so the counter may step past MUL_LAT-1
  // on the final RUN cycle without wrapping.
  localparam int CNT_W = $clog2(MUL_LAT + 1);

  typedef enum logic [1:0] {IDLE, RUN, CAPT, RESP} state_t;

  state_t           state;
  logic [ID_W-1:0]  rr_ptr;
  logic [CNT_W-1:0] lat_cnt;
  logic             found;
  logic [ID_W-1:0]  grant_idx;
  int               k;

  // First valid requester at or above rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    k         = 0;
    for (int i = 0; i < N_REQ; i++) begin
      k = int'(rr_ptr) + i;
      if (k >= N_REQ) k = k - N_REQ;
      if (!found && bus.req_valid[k]) begin
        found     = 1'b1;
        grant_idx = ID_W'(k);
      end
    end
  end

  // The grant is offered only in IDLE, so the handshake completes the same cycle.
  assign bus.req_ready = (state == IDLE && found) ? (N_REQ'(1) << grant_idx) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      lat_cnt       <= '0;
      mul_en        <= 1'b0;
      busy          <= 1'b0;
      mul_a         <= '0;
      mul_b         <= '0;
      bus.res_valid <= 1'b0;
      bus.res_data  <= '0;
      bus.res_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            mul_a      <= bus.req_a[int'(grant_idx)*WIDTH_A +: WIDTH_A];
            mul_b      <= bus.req_b[int'(grant_idx)*WIDTH_B +: WIDTH_B];
            bus.res_id <= grant_idx;
            rr_ptr     <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
            lat_cnt    <= '0;
            mul_en     <= 1'b1;
            busy       <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          lat_cnt <= lat_cnt + CNT_W'(1);
          if (lat_cnt == CNT_W'(MUL_LAT - 1)) begin
            mul_en <= 1'b0;
            state  <= CAPT;
          end
        end
        CAPT: begin
          // The engine finished its last step on the previous edge.
          bus.res_data  <= mul_out;
          bus.res_valid <= 1'b1;
          state         <= RESP;
        end
        RESP: begin
          if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
            busy          <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BOOTH_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count    <= '0;
      stall_count <= '0;
    end else if (state == RESP) begin
      if (bus.res_ready) op_count <= op_count + 32'd1;
      else if (stall_count != '1) stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// tb/tb_booth_mul_arbiter.sv - self-checking bench for booth_mul_arbiter with a behavioural engine

module tb_booth_mul_arbiter;
  localparam int N_REQ   = 4;
  localparam int ID_W    = 2;
  localparam int WA      = 16;
  localparam int WB      = 16;
  localparam int WM      = 32;
  localparam int MUL_LAT = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  booth_mul_arbiter_if #(.N_REQ(N_REQ), .ID_W(ID_W), .WIDTH_A(WA), .WIDTH_B(WB), .WIDTH_MUL(WM)) bus ();

  logic          busy, mul_en;
  logic [WA-1:0] mul_a;
  logic [WB-1:0] mul_b;
  logic [WM-1:0] mul_out;
`ifdef BOOTH_ARB_STATS_EN
  logic [31:0]   op_count, stall_count;
`endif

  booth_mul_arbiter #(
    .N_REQ(N_REQ), .ID_W(ID_W), .WIDTH_A(WA), .WIDTH_B(WB), .WIDTH_MUL(WM), .MUL_LAT(MUL_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .mul_en(mul_en),
    .mul_a(mul_a), .mul_b(mul_b), .mul_out(mul_out)
`ifdef BOOTH_ARB_STATS_EN
    , .op_count(op_count), .stall_count(stall_count)
`endif
  );

  // Engine stand-in: clears on its first enabled step and only shows the
  // product after exactly MUL_LAT enabled steps.
  int eng_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_cnt <= 0;
      mul_out <= '0;
    end else if (mul_en) begin
      if (eng_cnt == MUL_LAT - 1) begin
        eng_cnt <= 0;
        mul_out <= WM'(mul_a) * WM'(mul_b);
      end else begin
        eng_cnt <= eng_cnt + 1;
        if (eng_cnt == 0) mul_out <= '0;
      end
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for a grant; returns at posedge+1 of the first RUN cycle.
  task automatic wait_grant(output bit got, output logic [N_REQ-1:0] rdy);
    got = 1'b0;
    rdy = '0;
    for (int i = 0; i < 30 && !got; i++) begin
      #1;
      if (bus.req_ready != '0) begin
        got = 1'b1;
        rdy = bus.req_ready;
      end
      step();
    end
  endtask

  typedef struct {
    logic [3:0]  mask;
    logic [63:0] a;
    logic [63:0] b;
    logic [1:0]  id;
    logic [31:0] data;
  } vec_t;

  vec_t vecs[4];

  task automatic run_vec(input vec_t v, input int tag);
    bit got;
    logic [N_REQ-1:0] rdy;
    int n, en_cnt;
    bus.req_valid = v.mask;
    bus.req_a     = v.a;
    bus.req_b     = v.b;
    bus.res_ready = 1'b1;
    wait_grant(got, rdy);
    bus.req_valid = '0;
    chk($sformatf("v%0d grant", tag), {63'd0, got}, 64'd1);
    if (!got) return;
    chk($sformatf("v%0d req_ready", tag), 64'(rdy), 64'(4'b0001 << v.id));
    chk($sformatf("v%0d mul_a", tag), 64'(mul_a), 64'(v.a[int'(v.id)*WA +: WA]));
    n = 1;
    en_cnt = 0;
    while (n < 40 && !bus.res_valid) begin
      en_cnt += int'(mul_en);
      step();
      n++;
    end
    chk($sformatf("v%0d latency", tag), 64'(n), 64'(MUL_LAT + 2));
    chk($sformatf("v%0d mul_en cycles", tag), 64'(en_cnt), 64'(MUL_LAT));
    chk($sformatf("v%0d res_data", tag), 64'(bus.res_data), 64'(v.data));
    chk($sformatf("v%0d res_id", tag), 64'(bus.res_id), 64'(v.id));
    step();
    chk($sformatf("v%0d res_valid drop", tag), 64'(bus.res_valid), 64'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " req_ready"}, 64'(bus.req_ready), 64'd0);
    chk({tag, " res_valid"}, 64'(bus.res_valid), 64'd0);
    chk({tag, " res_data"},  64'(bus.res_data),  64'd0);
    chk({tag, " res_id"},    64'(bus.res_id),    64'd0);
    chk({tag, " mul_en"},    64'(mul_en),        64'd0);
    chk({tag, " mul_a"},     64'(mul_a),         64'd0);
    chk({tag, " mul_b"},     64'(mul_b),         64'd0);
    chk({tag, " busy"},      64'(busy),          64'd0);
  endtask

  initial begin
    logic [N_REQ-1:0] g_val[$];
    int               g_cyc[$];
    logic [31:0]      r_data[$];
    logic [1:0]       r_id[$];
    int               cyc;
    bit               got, bad;
    logic [N_REQ-1:0] rdy;
    vec_t             vr;

    // Large values from rr_ptr=0; then rr_ptr=1 -> 2 granted -> rr_ptr=3;
    // only requester 1 valid wraps to it -> rr_ptr=2; {1,3} then picks 3.
    vecs[0] = '{4'b0001, {4{16'hFFFF}}, {4{16'hFFFF}}, 2'd0, 32'hFFFE0001};
    vecs[1] = '{4'b0100, {16'd9, 16'd3, 16'd8, 16'd7}, {4{16'd5}}, 2'd2, 32'd15};
    vecs[2] = '{4'b0010, {16'd1, 16'd2, 16'd11, 16'd4}, {4{16'd13}}, 2'd1, 32'd143};
    vecs[3] = '{4'b1010, {16'd100, 16'd2, 16'd50, 16'd4}, {16'd300, 16'd1, 16'd7, 16'd1}, 2'd3, 32'd30000};

    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.res_ready = 1'b0;
    step();
    step();
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 4; i++) run_vec(vecs[i], i);

    // Round robin with every requester continuously valid.
    bus.req_a     = {16'd4, 16'd3, 16'd2, 16'd1};
    bus.req_b     = {4{16'd10}};
    bus.req_valid = 4'b1111;
    bus.res_ready = 1'b1;
    cyc = 0;
    while (r_id.size() < 5 && cyc < 100) begin
      #1;
      if (bus.req_ready != '0) begin
        g_val.push_back(bus.req_ready);
        g_cyc.push_back(cyc);
      end
      if (bus.res_valid) begin
        r_data.push_back(bus.res_data);
        r_id.push_back(bus.res_id);
      end
      step();
      cyc++;
    end
    bus.req_valid = '0;
    chk("rr result count", 64'(r_id.size()), 64'd5);
    for (int i = 0; i < r_id.size(); i++) begin
      chk($sformatf("rr%0d id", i), 64'(r_id[i]), 64'(i % 4));
      chk($sformatf("rr%0d data", i), 64'(r_data[i]), 64'((i % 4 + 1) * 10));
    end
    for (int i = 0; i < g_val.size() && i < 5; i++)
      chk($sformatf("rr%0d grant", i), 64'(g_val[i]), 64'(4'b0001 << (i % 4)));
    for (int i = 1; i < g_cyc.size() && i < 5; i++)
      chk($sformatf("rr%0d spacing", i), 64'(g_cyc[i] - g_cyc[i-1]), 64'(MUL_LAT + 3));

    // Back-pressure: rr_ptr=1, only requester 0 valid at first.
    bus.req_a     = {4{16'd9}};
    bus.req_b     = {4{16'd9}};
    bus.req_valid = 4'b0001;
    bus.res_ready = 1'b0;
    wait_grant(got, rdy);
    chk("bp grant", 64'(rdy), 64'h1);
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 30 && !bus.res_valid; i++) step();
    chk("bp res_valid", 64'(bus.res_valid), 64'd1);
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (bus.res_valid !== 1'b1 || bus.res_data !== 32'd81 || bus.res_id !== 2'd0 ||
          bus.req_ready !== 4'b0000)
        bad = 1'b1;
      step();
    end
    chk("bp stable", 64'(bad), 64'd0);
`ifdef BOOTH_ARB_STATS_EN
    chk("bp stall_count", 64'(stall_count), 64'd20);
`endif
    bus.res_ready = 1'b1;
    step();
    #1;
    chk("bp next grant", 64'(bus.req_ready), 64'h2);
`ifdef BOOTH_ARB_STATS_EN
    chk("op_count", 64'(op_count), 64'd10);
`endif
    step();
    bus.req_valid = '0;
    for (int i = 0; i < 30 && !bus.res_valid; i++) step();
    chk("bp2 res_data", 64'(bus.res_data), 64'd81);
    chk("bp2 res_id", 64'(bus.res_id), 64'd1);
    step();

    // Reset on RUN cycle 4 (rr_ptr=2 so requester 2 is granted).
    bus.req_a     = {4{16'd100}};
    bus.req_b     = {4{16'd3}};
    bus.req_valid = 4'b0100;
    wait_grant(got, rdy);
    bus.req_valid = '0;
    chk("mid grant", 64'(rdy), 64'h4);
    step();
    step();
    step();
    chk("mid in RUN", 64'(mul_en), 64'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid reset");
    step();
    step();
    rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (bus.res_valid !== 1'b0) bad = 1'b1;
      step();
    end
    chk("mid no result", 64'(bad), 64'd0);
    // rr_ptr back at 0: with {1,2} valid requester 1 must win.
    vr = '{4'b0110, {16'd9, 16'd8, 16'd7, 16'd5}, {4{16'd6}}, 2'd1, 32'd42};
    run_vec(vr, 9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/booth_mul_arbiter.md
Name: booth_mul_arbiter

Overview:
- Shares one iterative radix-4 Booth multiplier engine between N_REQ requesters.
- Each requester presents an operand pair with a valid/ready handshake. The block picks one requester round-robin, latches its operands and drives the engine enable for a fixed MUL_LAT cycles.
- It then captures the product and returns it with the requester's index on a valid/ready result channel.
- Sits between systolic-array processing-element clusters and a single shared multiplier.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of res_id; must be >= clog2(N_REQ).
- WIDTH_A, 16, operand A width.
- WIDTH_B, 16, operand B width.
- WIDTH_MUL, WIDTH_A+WIDTH_B, product width.
- MUL_LAT, 9, number of consecutive mul_en-high cycles the engine needs per product. Must be >= 1. Value 9 suits a 16x16 unsigned engine with no output pipeline: (16+1)/2 accumulate cycles plus 1 capture cycle. After MUL_LAT cycles the engine has returned to its idle state.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  N_REQ  per-requester request valid
- req_ready  out  N_REQ  per-requester accept; one-hot or zero
- req_a  in  N_REQ*WIDTH_A  packed A operands; requester k uses bits [k*WIDTH_A +: WIDTH_A]
- req_b  in  N_REQ*WIDTH_B  packed B operands; same packing as req_a
- res_valid  out  1  result valid
- res_ready  in  1  result accept
- res_data  out  WIDTH_MUL  product
- res_id  out  ID_W  index of the requester that owns res_data
- busy  out  1  high in any state other than IDLE
- mul_en  out  1  engine step enable
- mul_a  out  WIDTH_A  engine operand A, driven from a register
- mul_b  out  WIDTH_B  engine operand B, driven from a register
- mul_out  in  WIDTH_MUL  engine product

Behaviour:

Reset values:
- Asynchronous reset clears all state: state=IDLE, rr_ptr=0, lat_cnt=0.
- Outputs after reset: req_ready=0, res_valid=0, res_data=0, res_id=0, mul_en=0, mul_a=0, mul_b=0, busy=0.

State IDLE:
- If any req_valid bit is set, grant g = the first set bit searching upward from rr_ptr, wrapping modulo N_REQ.
- req_ready[g]=1 combinationally for this one cycle; the handshake completes in this cycle.
- On that edge: mul_a/mul_b <= requester g's operands; res_id <= g; rr_ptr <= (g+1) mod N_REQ; lat_cnt <= 0; state -> RUN.
- req_ready is 0 in every other state and 0 in IDLE when no req_valid bit is set.

State RUN:
- mul_en=1. lat_cnt increments each cycle.
- When lat_cnt == MUL_LAT-1, go to CAPT. RUN therefore lasts exactly MUL_LAT cycles.
- mul_a and mul_b stay stable for the whole operation.

State CAPT:
- mul_en=0 for one cycle.
- res_data <= mul_out; state -> RESP.

State RESP:
- res_valid=1; res_data and res_id are held stable.
- When res_valid && res_ready: state -> IDLE.
- Back-pressure may hold RESP indefinitely; no new grant is made during this time.

Throughput and latency:
- One product per MUL_LAT+3 cycles when res_ready is tied high.
- Latency from req handshake to res_valid = MUL_LAT+2 cycles.

Requester protocol:
- A requester holds req_valid and its operands stable until it sees req_ready.
- Changes to req_valid in non-IDLE states are ignored.
- A requester that drops req_valid before being granted is simply not granted.

Fairness:
- With all requesters continuously valid, grants rotate 0,1,2,...,N_REQ-1,0,...
- A single requester can be granted back-to-back.

Reset mid-operation:
- Aborts the operation immediately. The in-flight result is discarded, no res_valid is raised, and rr_ptr returns to 0.

Optional Feature:
- Macro BOOTH_ARB_STATS_EN.
- When defined, the block adds two outputs:
  - op_count, out, 32 bits: increments on each result handshake and wraps modulo 2^32.
  - stall_count, out, 32 bits: increments on each RESP cycle with res_ready=0 and saturates at all ones.
  - Both reset to 0.
- When undefined, neither port nor counter exists and behaviour is otherwise identical.

Test Plan:
Bench connects the team's radix-4 Booth engine (unsigned, 16x16, no approximation, no output pipeline) with MUL_LAT=9.
- Single request: req_valid[2]=1, A=3, B=5, res_ready=1 -> req_ready[2] for one cycle; mul_en high exactly 9 cycles; res_valid 11 cycles after the handshake; res_data=15; res_id=2.
- Large values: req_valid[0]=1, A=16'hFFFF, B=16'hFFFF -> res_data=32'hFFFE0001, res_id=0.
- Round robin: all 4 requesters valid with A=k+1, B=10 -> results in order id 0,1,2,3,0 with res_data 10,20,30,40,10; each subsequent grant lands 12 cycles after the previous one.
- Back-pressure: res_ready=0 for 20 cycles during RESP -> res_valid, res_data and res_id stable; req_ready stays 0; with the macro defined, stall_count=20. After res_ready rises, the next grant follows 1 cycle after leaving RESP.
- Reset mid-operation: assert rst_n=0 on RUN cycle 4 -> all outputs return to their reset values immediately; after release, a fresh request with A=7, B=6 gives res_data=42.
- Pointer wrap: rr_ptr=3 with only req_valid[1] set -> requester 1 is granted and rr_ptr becomes 2.
